// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between four byte requesters: round-robin arbitration,
// Tx_WR/Tx_BUSY handshake per byte, and a grant lock held until the owner's last byte.
module uart_tx_scheduler #(
    parameter int BUSY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  gnt,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    input  logic        Tx_BUSY,
    output logic        active,
    output logic [1:0]  owner,
    output logic        tx_err,
    input  logic        err_clr
);

    localparam int CntW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t          state_q;
    logic [1:0]      ptr_q;
    logic [1:0]      owner_q;
    logic [3:0]      gnt_q;
    logic [7:0]      data_q;
    logic            wr_q;
    logic            active_q;
    logic            err_q;
    logic            last_q;
    logic [CntW-1:0] cnt_q;

    logic            pickValid;
    logic [1:0]      pickIdx;
    logic            grantFire;
    logic [1:0]      grantIdx;

    // Walk the search order backwards so the candidate closest to ptr is the one left standing.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr_q + 2'(k)]) begin
                pickValid = 1'b1;
                pickIdx   = ptr_q + 2'(k);
            end
        end
        grantFire = en && (((state_q == IDLE) && pickValid) ||
                           ((state_q == HOLD) && req[owner_q]));
        grantIdx  = (state_q == HOLD) ? owner_q : pickIdx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= 2'd0;
            owner_q  <= 2'd0;
            gnt_q    <= 4'd0;
            data_q   <= 8'h00;
            wr_q     <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            gnt_q <= 4'd0;
            wr_q  <= 1'b0;
            // A timeout later in this block overrides the clear.
            if (err_clr) begin
                err_q <= 1'b0;
            end
            case (state_q)
                IDLE, HOLD: begin
                    if (grantFire) begin
                        data_q   <= req_data[{grantIdx, 3'b000} +: 8];
                        last_q   <= req_last[grantIdx];
                        owner_q  <= grantIdx;
                        gnt_q    <= 4'b0001 << grantIdx;
                        wr_q     <= 1'b1;
                        active_q <= 1'b1;
                        state_q  <= ISSUE;
                    end else if ((state_q == HOLD) && !en) begin
                        ptr_q    <= owner_q + 2'd1;
                        active_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state_q <= WAIT_DONE;
                    end else if (cnt_q == CntLast) begin
                        err_q <= 1'b1;
                        if (last_q) begin
                            ptr_q    <= owner_q + 2'd1;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        if (last_q) begin
                            ptr_q    <= owner_q + 2'd1;
                            active_q <= 1'b0;
                            state_q  <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign Tx_DATA = data_q;
    assign Tx_WR   = wr_q;
    assign Tx_EN   = en;
    assign active  = active_q;
    assign owner   = owner_q;
    assign tx_err  = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-driven requesters, a simple transmitter model and a
// transaction-level arbitration model checked against the DUT every cycle.
module tb_uart_tx_scheduler;

    localparam int BusyTimeout = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic [7:0]  Tx_DATA;
    logic        Tx_WR;
    logic        Tx_EN;
    logic        Tx_BUSY;
    logic        active;
    logic [1:0]  owner;
    logic        tx_err;
    logic        err_clr;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.BUSY_TIMEOUT(BusyTimeout)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .gnt      (gnt),
        .Tx_DATA  (Tx_DATA),
        .Tx_WR    (Tx_WR),
        .Tx_EN    (Tx_EN),
        .Tx_BUSY  (Tx_BUSY),
        .active   (active),
        .owner    (owner),
        .tx_err   (tx_err),
        .err_clr  (err_clr)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [8:0] mem [4][32];
    int head [4];
    int tail [4];

    logic [1:0] mPtr;
    logic       mLocked;
    logic [1:0] mOwner;
    logic [7:0] mData;
    int         logW[$];
    logic [7:0] logD[$];
    logic [3:0] lastGntVec;
    int         lastWrCyc;
    int         seqW [8];
    logic [7:0] seqD [8];

    logic [3:0]  snapReq;
    logic [3:0]  snapLast;
    logic [31:0] snapData;
    logic        snapEn;

    int   busyLen = 10;
    int   busyTimer;
    int   startDelay;
    logic busyStuck;

    // Inputs as the DUT saw them at the most recent rising edge.
    always @(posedge clk) begin
        snapReq  <= req;
        snapLast <= req_last;
        snapData <= req_data;
        snapEn   <= en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic int pickWinner(input logic [3:0] r, input logic [1:0] p);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(p) + k) % 4]) return (int'(p) + k) % 4;
        end
        return -1;
    endfunction

    function automatic int firstIdx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic int logWAt(input int i);
        if (i < logW.size()) return logW[i];
        return -1;
    endfunction

    function automatic int logDAt(input int i);
        if (i < logD.size()) return int'(logD[i]);
        return -1;
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][tail[r]] = {l, d};
        tail[r]++;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) begin
            if (head[i] < tail[i]) begin
                req[i]            = 1'b1;
                req_data[8*i +: 8] = mem[i][head[i]][7:0];
                req_last[i]       = mem[i][head[i]][8];
            end else begin
                req[i]            = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    endtask

    task automatic modelReset();
        mPtr       = 2'd0;
        mLocked    = 1'b0;
        mOwner     = 2'd0;
        mData      = 8'h00;
        Tx_BUSY    = 1'b0;
        busyTimer  = 0;
        startDelay = 0;
    endtask

    // Per-cycle comparison: who should win, which byte goes out, and what stays stable.
    task automatic checkOutput();
        int w;
        int expW;
        if (reset) begin
            check("rst_gnt", 32'(gnt), 32'd0);
            check("rst_wr", 32'(Tx_WR), 32'd0);
        end else if (gnt != 4'b0) begin
            w = firstIdx(gnt);
            expW = mLocked ? int'(mOwner) : pickWinner(snapReq, mPtr);
            check("gnt_onehot", 32'($countones(gnt)), 32'd1);
            check("gnt_en", 32'(snapEn), 32'd1);
            check("gnt_who", 32'(w), 32'(expW));
            check("gnt_req", 32'(snapReq[w]), 32'd1);
            if (expW >= 0) begin
                mData  = snapData[8*expW +: 8];
                mOwner = 2'(expW);
                if (snapLast[expW]) begin
                    mLocked = 1'b0;
                    mPtr    = 2'(expW + 1);
                end else begin
                    mLocked = 1'b1;
                end
                logD.push_back(mData);
            end else begin
                logD.push_back(8'h00);
            end
            logW.push_back(w);
            lastGntVec = gnt;
            lastWrCyc  = cyc;
            if (head[w] < tail[w]) head[w]++;
        end
        check("txwr", 32'(Tx_WR), 32'(gnt != 4'b0));
        check("txen", 32'(Tx_EN), 32'(en));
        check("txdata", 32'(Tx_DATA), 32'(mData));
        check("owner", 32'(owner), 32'(mOwner));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        checkOutput();
        if (busyTimer > 0) begin
            busyTimer--;
            if (busyTimer == 0) Tx_BUSY = 1'b0;
        end
        if (startDelay > 0) begin
            startDelay--;
            if (startDelay == 0) begin
                Tx_BUSY   = 1'b1;
                busyTimer = busyLen;
            end
        end
        if (Tx_WR && !busyStuck) startDelay = 1;
        applyStimulus();
    endtask

    task automatic waitGrants(input int target, input int bound, input string name);
        int n = 0;
        while (logW.size() < target && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(logW.size() >= target), 32'd1);
    endtask

    task automatic waitIdle(input int bound, input string name);
        int n = 0;
        while (active !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(active), 32'd0);
    endtask

    task automatic doReset();
        for (int i = 0; i < 4; i++) head[i] = tail[i];
        applyStimulus();
        reset = 1'b1;
        modelReset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic checkSeq(input string tag, input int base, input int n);
        for (int j = 0; j < n; j++) begin
            check({tag, "_who"}, 32'(logWAt(base + j)), 32'(seqW[j]));
            check({tag, "_data"}, 32'(logDAt(base + j)), 32'(seqD[j]));
        end
    endtask

    initial begin
        int base;
        int t0;
        reset = 1'b1; en = 1'b0; err_clr = 1'b0; busyStuck = 1'b0;
        req = 4'd0; req_data = 32'd0; req_last = 4'd0;
        lastGntVec = 4'd0; lastWrCyc = 0;
        for (int i = 0; i < 4; i++) begin head[i] = 0; tail[i] = 0; end
        modelReset();
        tick();
        tick();
        check("rst_active", 32'(active), 32'd0);
        check("rst_txdata", 32'(Tx_DATA), 32'h00);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_txerr", 32'(tx_err), 32'd0);
        reset = 1'b0;
        en    = 1'b1;

        // Single byte from requester 0, then confirm the pointer moved to 1.
        push(0, 8'hA5, 1'b1);
        applyStimulus();
        waitGrants(1, 20, "t1_wait");
        check("t1_gnt", 32'(lastGntVec), 32'b0001);
        check("t1_data", 32'(logDAt(0)), 32'hA5);
        waitIdle(60, "t1_idle");
        push(0, 8'h50, 1'b1);
        push(1, 8'h51, 1'b1);
        applyStimulus();
        waitGrants(3, 80, "t1_ptr_wait");
        check("t1_ptr_first", 32'(logWAt(1)), 32'd1);
        check("t1_ptr_second", 32'(logWAt(2)), 32'd0);
        waitIdle(60, "t1_ptr_idle");

        // Fairness with all four requesting two single-byte messages each.
        doReset();
        base = logW.size();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++)
                push(i, 8'(8'h30 + 16*k + i), 1'b1);
        applyStimulus();
        waitGrants(base + 8, 400, "fair_wait");
        seqW = '{0, 1, 2, 3, 0, 1, 2, 3};
        seqD = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43};
        checkSeq("fair", base, 8);
        waitIdle(60, "fair_idle");

        // Burst lock: move the pointer to 2, then requester 2 sends three bytes amid others.
        doReset();
        push(1, 8'h11, 1'b1);
        applyStimulus();
        waitGrants(logW.size() + 1, 20, "burst_setup");
        waitIdle(60, "burst_setup_idle");
        base = logW.size();
        push(2, 8'hB0, 1'b0); push(2, 8'hB1, 1'b0); push(2, 8'hB2, 1'b1);
        push(0, 8'hD0, 1'b1); push(1, 8'hD1, 1'b1); push(3, 8'hD3, 1'b1);
        applyStimulus();
        waitGrants(base + 6, 600, "burst_wait");
        seqW = '{2, 2, 2, 3, 0, 1, 0, 0};
        seqD = '{8'hB0, 8'hB1, 8'hB2, 8'hD3, 8'hD0, 8'hD1, 8'h00, 8'h00};
        checkSeq("burst", base, 6);
        waitIdle(60, "burst_idle");

        // Timeout: the edge ending the Tx_WR cycle plus 64 counted cycles.
        busyStuck = 1'b1;
        push(0, 8'hE0, 1'b1);
        applyStimulus();
        waitGrants(logW.size() + 1, 20, "to_wait");
        t0 = lastWrCyc;
        while (tx_err !== 1'b1 && cyc < t0 + 200) tick();
        check("to_delay", 32'(cyc - t0), 32'd65);
        check("to_active", 32'(active), 32'd0);
        tick(); tick(); tick();
        check("to_sticky", 32'(tx_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_clear", 32'(tx_err), 32'd0);
        push(1, 8'hE1, 1'b1);
        applyStimulus();
        waitGrants(logW.size() + 1, 20, "to2_wait");
        t0 = lastWrCyc;
        while (cyc < t0 + 64) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("to_setwins", 32'(tx_err), 32'd1);
        tick();
        check("to_setwins_hold", 32'(tx_err), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        busyStuck = 1'b0;

        // en drop while the grant is locked in HOLD.
        doReset();
        base = logW.size();
        push(1, 8'h61, 1'b0);
        push(2, 8'h62, 1'b1);
        applyStimulus();
        waitGrants(base + 1, 20, "en_wait");
        repeat (20) tick();
        check("en_hold_active", 32'(active), 32'd1);
        check("en_hold_nogrant", 32'(logW.size()), 32'(base + 1));
        en      = 1'b0;
        mLocked = 1'b0;
        mPtr    = 2'(mOwner + 2'd1);
        push(3, 8'h63, 1'b1);
        push(1, 8'h71, 1'b1);
        applyStimulus();
        tick();
        tick();
        check("en_release_active", 32'(active), 32'd0);
        check("en_txen", 32'(Tx_EN), 32'd0);
        repeat (8) tick();
        check("en_nogrant", 32'(logW.size()), 32'(base + 1));
        en = 1'b1;
        waitGrants(base + 4, 200, "en_resume_wait");
        seqW = '{1, 2, 3, 1, 0, 0, 0, 0};
        seqD = '{8'h61, 8'h62, 8'h63, 8'h71, 8'h00, 8'h00, 8'h00, 8'h00};
        checkSeq("en", base, 4);
        waitIdle(60, "en_idle");

        // Asynchronous reset while the transmitter is busy on a burst byte.
        doReset();
        base = logW.size();
        push(3, 8'h91, 1'b0);
        push(3, 8'h92, 1'b1);
        applyStimulus();
        waitGrants(base + 1, 20, "mid_wait");
        for (int n = 0; n < 20 && Tx_BUSY !== 1'b1; n++) tick();
        check("mid_busy_seen", 32'(Tx_BUSY), 32'd1);
        tick();
        push(0, 8'h90, 1'b1);
        applyStimulus();
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_wr", 32'(Tx_WR), 32'd0);
        check("mid_rst_data", 32'(Tx_DATA), 32'h00);
        check("mid_rst_active", 32'(active), 32'd0);
        check("mid_rst_owner", 32'(owner), 32'd0);
        check("mid_rst_err", 32'(tx_err), 32'd0);
        modelReset();
        tick();
        tick();
        reset = 1'b0;
        waitGrants(base + 3, 200, "mid_after_wait");
        seqW = '{3, 0, 3, 0, 0, 0, 0, 0};
        seqD = '{8'h91, 8'h90, 8'h92, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        checkSeq("mid", base, 3);
        waitIdle(60, "mid_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL global_timeout: got cycle %0d, want completion", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Controller that shares one uart_transmitter between four byte requesters. It arbitrates round-robin among requesters. It drives the transmitter's Tx_DATA/Tx_WR/Tx_EN handshake and waits on Tx_BUSY for each byte. It holds the grant for multi-byte messages until the owner marks the last byte. It sits on clk1 between the byte sources and the encoder/transmitter path of the UART system.

## Interface
- BUSY_TIMEOUT, default 64: cycles to wait for Tx_BUSY to rise after Tx_WR before flagging an error.
- clk  input  1  system clock (transmitter clock domain).
- reset  input  1  asynchronous, active-high reset.
- en  input  1  scheduler enable; passed to Tx_EN; low blocks new grants.
- req  input  4  per-requester byte-valid; bit i belongs to requester i.
- req_data  input  32  requester i's byte on req_data[8i+7:8i].
- req_last  input  4  bit i high marks requester i's current byte as the message's last byte.
- gnt  output  4  one-cycle pulse: requester i's byte has been consumed.
- Tx_DATA  output  8  byte to the transmitter (pre-encoder).
- Tx_WR  output  1  one-cycle write strobe to the transmitter.
- Tx_EN  output  1  transmitter enable; equals en.
- Tx_BUSY  input  1  transmitter busy.
- active  output  1  high whenever the state is not IDLE.
- owner  output  2  index of the current or most recent grantee.
- tx_err  output  1  sticky Tx_BUSY-timeout flag.
- err_clr  input  1  clears tx_err; a same-cycle set wins.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, HOLD.
- Round-robin pointer ptr[1:0]: search order is ptr, ptr+1, … mod 4. Reset value 0.
- IDLE: if en and |req, the first set bit in search order wins.
  - Latch req_data byte into Tx_DATA and req_last bit into last_r.
  - owner <= winner; gnt[winner] pulses; go to ISSUE.
- ISSUE: Tx_WR=1 for exactly this cycle; cnt cleared; go to WAIT_BUSY.
- WAIT_BUSY:
  - If Tx_BUSY: go to WAIT_DONE.
  - Else if cnt==BUSY_TIMEOUT-1: set tx_err, then apply the release rule below.
  - Else cnt++.
- WAIT_DONE: when Tx_BUSY low, apply the release rule.
- Release rule:
  - If last_r=1: ptr <= owner+1 (wraps 3→0); go to IDLE.
  - Else: go to HOLD.
- HOLD (message lock):
  - If en=0: release (ptr <= owner+1, go to IDLE).
  - Else if req[owner]: latch that requester's byte and last bit, pulse gnt[owner], go to ISSUE.
  - Requests from other requesters are ignored while in HOLD.
- Tx_DATA is stable from the latching edge until the next latch.
- gnt is never multi-hot and never asserted outside a latching transition.
- en drop: does not abort a byte already in ISSUE/WAIT_*; it only blocks new grants and releases HOLD.
- Reset values: state IDLE, ptr 0, owner 0, gnt 0, Tx_DATA 0x00, Tx_WR 0, active 0, tx_err 0, cnt 0, last_r 0. Tx_EN follows en combinationally.
- Reset mid-operation: immediate return to reset values. No Tx_WR or gnt is issued until after reset deasserts.

## Timing
- All outputs except Tx_EN are registered.
- A req sampled at edge k (state IDLE or HOLD) gives gnt and Tx_WR both high in cycle k..k+1.
- A requester must advance its req/req_data/req_last at the edge ending its gnt cycle.
- The earliest edge at which the next request is sampled is the edge after Tx_BUSY is seen low in WAIT_DONE.
- For a back-to-back burst, the cycle overhead per byte beyond the transmitter busy time is 3.
- Timeout path: tx_err rises BUSY_TIMEOUT cycles after the Tx_WR cycle.
- Simultaneous events:
  - req on all bits: the lowest index at or above ptr wins.
  - err_clr together with a timeout: tx_err stays 1.

## Test plan
- Single byte: reset; req=0001, req_data[7:0]=0xA5, req_last=1; model busy 1 cycle after Tx_WR for 10 cycles. Expected: gnt=0001 and Tx_WR together, Tx_DATA=0xA5, back to IDLE, ptr=1, active low.
- Fairness: req=1111 held, all last=1, 8 bytes. Expected grant order 0,1,2,3,0,1,2,3, one gnt per byte, with Tx_DATA matching each source.
- Burst lock: requester 2 sends 3 bytes (last only on the third) while req=1011 is asserted. Expected: three consecutive gnt=0100 pulses with owner=2 throughout, then next grant to requester 3.
- Timeout: Tx_BUSY tied 0, BUSY_TIMEOUT=64. Expected: tx_err=1 exactly 64 cycles after Tx_WR, scheduler returns to IDLE; err_clr pulse clears tx_err.
- en control: drop en during HOLD. Expected: release to IDLE, no gnt while en=0, Tx_EN=0. Raise en: arbitration resumes at owner+1.
- Reset mid-burst: assert reset in WAIT_DONE. Expected: all outputs at reset values asynchronously, and the next grant after deassertion follows ptr=0 order.
